// File: rtl/mvau_pkg.sv
// rtl/mvau_pkg.sv - shared MVAU types and fold-size helpers
package mvau_pkg;

   // Buffer sequencer state: FILL streams from the input, REPLAY reads the stored vector
   typedef enum logic {
      FILL   = 1'b0,
      REPLAY = 1'b1
   } mvau_buf_state_t;

   // Column folds per input vector
   function automatic int calc_sf(input int matrix_w, input int simd);
      return matrix_w / simd;
   endfunction

   // Neuron folds per output vector
   function automatic int calc_nf(input int matrix_h, input int pe);
      return matrix_h / pe;
   endfunction

   // Counter width that never collapses to zero bits
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mvau_act_buffer_if.sv
// rtl/mvau_act_buffer_if.sv - activation input stream and fold-sequenced output bundle
interface mvau_act_buffer_if #(
   parameter int TI = 8,
   parameter int AW = 3
);
   logic          in_v;
   logic          in_rdy;
   logic [TI-1:0] in_act;
   logic          out_rdy;
   logic          out_v;
   logic [TI-1:0] out_act;
   logic [AW-1:0] wmem_addr;
   logic          sf_last;
   logic          nf_last;

   // Upstream source plus downstream consumer (the side driving the buffer)
   modport master (
      output in_v, in_act, out_rdy,
      input  in_rdy, out_v, out_act, wmem_addr, sf_last, nf_last
   );

   // The activation buffer itself
   modport slave (
      input  in_v, in_act, out_rdy,
      output in_rdy, out_v, out_act, wmem_addr, sf_last, nf_last
   );
endinterface

// File: rtl/mvau_act_mem.sv
// rtl/mvau_act_mem.sv - one-vector activation store with registered read port
module mvau_act_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage array is never reset: every word is rewritten before it is replayed
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register doubles as the output activation register; writes pass straight through
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i) begin
         rdata_q <= we_i ? wdata_i : mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mvau_act_buffer.sv
// rtl/mvau_act_buffer.sv - activation buffer and neuron-fold replay sequencer for mvu_comp
module mvau_act_buffer
   import mvau_pkg::*;
#(
   parameter int SIMD    = 2,
   parameter int PE      = 2,
   parameter int TSrcI   = 4,
   parameter int MatrixW = 8,
   parameter int MatrixH = 4
) (
   input logic              clk,
   input logic              rst_n,
   mvau_act_buffer_if.slave bus
);
   localparam int SF  = calc_sf(MatrixW, SIMD);
   localparam int NF  = calc_nf(MatrixH, PE);
   localparam int TI  = SIMD * TSrcI;
   localparam int AW  = cnt_width(SF * NF);
   localparam int SFW = cnt_width(SF);
   localparam int NFW = cnt_width(NF);

   localparam logic [SFW-1:0] SF_MAX = SFW'(SF - 1);
   localparam logic [NFW-1:0] NF_MAX = NFW'(NF - 1);

   mvau_buf_state_t state_q, state_d;
   logic [SFW-1:0]  sf_q, sf_d;
   logic [NFW-1:0]  nf_q, nf_d;
   logic            out_v_q, out_v_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            sf_last_q, sf_last_d;
   logic            nf_last_q, nf_last_d;

   logic            is_fill;
   logic            adv;
   logic            sf_wrap;
   logic            nf_wrap;
   logic [TI-1:0]   act_rd;

   assign is_fill = (state_q == FILL);
   assign adv     = bus.out_rdy && (is_fill ? bus.in_v : 1'b1);
   assign sf_wrap = (sf_q == SF_MAX);
   assign nf_wrap = (nf_q == NF_MAX);

   // Next-state for fold counters, state and output flags; out_rdy low holds everything
   always_comb begin
      state_d   = state_q;
      sf_d      = sf_q;
      nf_d      = nf_q;
      out_v_d   = out_v_q;
      addr_d    = addr_q;
      sf_last_d = sf_last_q;
      nf_last_d = nf_last_q;
      if (bus.out_rdy) begin
         out_v_d = adv;
         if (adv) begin
            addr_d    = AW'(nf_q) * AW'(SF) + AW'(sf_q);
            sf_last_d = sf_wrap;
            nf_last_d = nf_wrap;
            if (sf_wrap) begin
               sf_d = '0;
               if (nf_wrap) begin
                  nf_d    = '0;
                  state_d = FILL;
               end else begin
                  nf_d    = nf_q + NFW'(1);
                  state_d = REPLAY;
               end
            end else begin
               sf_d = sf_q + SFW'(1);
            end
         end
      end
   end

   // Sequencer and output register; reset discards any partially delivered vector
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FILL;
         sf_q      <= '0;
         nf_q      <= '0;
         out_v_q   <= 1'b0;
         addr_q    <= '0;
         sf_last_q <= 1'b0;
         nf_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sf_q      <= sf_d;
         nf_q      <= nf_d;
         out_v_q   <= out_v_d;
         addr_q    <= addr_d;
         sf_last_q <= sf_last_d;
         nf_last_q <= nf_last_d;
      end
   end

   mvau_act_mem #(
      .DEPTH (SF),
      .WIDTH (TI),
      .AW    (SFW)
   ) u_act_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .we_i    (is_fill),
      .addr_i  (sf_q),
      .wdata_i (bus.in_act),
      .rdata_o (act_rd)
   );

   assign bus.in_rdy    = rst_n && bus.out_rdy && is_fill;
   assign bus.out_v     = out_v_q;
   assign bus.out_act   = act_rd;
   assign bus.wmem_addr = addr_q;
   assign bus.sf_last   = sf_last_q;
   assign bus.nf_last   = nf_last_q;

endmodule
